// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud helper
package uart_pkg;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int DATA_BITS = 8;
  function automatic int cycles_per_bit_f(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte stream handshake between receiver and consumer
interface uart_rx_if import uart_pkg::*; ();
  logic tvalid;
  logic tready;
  logic [DATA_BITS-1:0] tdata;
  modport master(output tvalid, tdata, input tready);
  modport slave(input tvalid, tdata, output tready);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer for asynchronous inputs
module sync_ff #(
  parameter int stages = 2,
  parameter logic reset_value = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [stages-1:0] r;
  always_ff @(posedge clk) r <= rst ? {stages{reset_value}} : {r[stages-2:0], d};
  assign q = r[stages-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver presenting bytes on a valid/ready stream
module uart_rx import uart_pkg::*; #(
  parameter int cycles_per_bit = 434,
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_rx_if.master axis,
  output logic framing_error,
  output logic overflow
);
  localparam int cw = $clog2(cycles_per_bit);
  localparam logic [cw-1:0] half_m1 = cw'(cycles_per_bit / 2 - 1);
  localparam logic [cw-1:0] bit_m1 = cw'(cycles_per_bit - 1);
  uart_rx_state_t state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic rx_s, stop_ok, stop_bad, load;
  sync_ff #(.stages(sync_stages), .reset_value(1'b1)) u_sync (.clk, .rst, .d(rx), .q(rx_s));
  assign load = stop_ok && (!axis.tvalid || axis.tready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      axis.tvalid <= 1'b0;
      axis.tdata <= '0;
      framing_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      framing_error <= stop_bad;
      overflow <= stop_ok && !load;
      axis.tvalid <= load || (axis.tvalid && !axis.tready);
      if (load) axis.tdata <= sh;
    end
  end
  // cnt counts cycles within the current phase; samples land at bit centres
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    stop_ok = 1'b0;
    stop_bad = 1'b0;
    case (state)
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (cnt == half_m1) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == bit_m1) begin
        cnt_n = '0;
        sh_n[idx] = rx_s;
        idx_n = idx + 1'b1;
        if (idx == 3'(DATA_BITS - 1)) state_n = STOP;
      end
      STOP: if (cnt == bit_m1) begin
        cnt_n = '0;
        stop_ok = rx_s;
        stop_bad = !rx_s;
        state_n = rx_s ? IDLE : WAIT_IDLE;
      end
      default: state_n = WAIT_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench driving serial frames into uart_rx
module tb_uart_rx;
  import uart_pkg::*;
  localparam int cpb = 16;
  localparam int half = cpb / 2;
  logic clk = 0, rst = 1, rx = 1, fe, ov;
  int total = 0, bad = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] got[$], exp_q[$];
  uart_rx_if bus();
  uart_rx #(.cycles_per_bit(cpb), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .axis(bus), .framing_error(fe), .overflow(ov)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (bus.tvalid && bus.tready) got.push_back(bus.tdata);
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bits(d[i], cpb);
    send_bits(stop, cpb);
  endtask
  task automatic clear_obs();
    got.delete();
    exp_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic test_reset();
    bus.tready = 1;
    repeat (3) tick();
    total++;
    if (bus.tvalid !== 1'b0 || bus.tdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_out got tvalid=%b tdata=%h exp tvalid=0 tdata=00", bus.tvalid, bus.tdata);
    end
    total++;
    if (fe !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulse got fe=%b ov=%b exp 0 0", fe, ov);
    end
    rst = 0;
    send_bits(1'b1, 4);
    total++;
    if (bus.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL idle_tvalid got %b exp 0", bus.tvalid);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    clear_obs();
    bus.tready = 1;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    total++;
    if (got.size() != 1 || got[0] !== 8'hA5) begin
      bad++;
      $display("FAIL single_a5 got n=%0d first=%h exp n=1 a5", got.size(), got.size() ? got[0] : 8'h00);
    end
    for (int k = 0; k < 7; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1);
    end
    send_bits(1'b1, 2 * cpb);
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      end
    end
    total++;
    if (fe_cnt != 0 || ov_cnt != 0) begin
      bad++;
      $display("FAIL b2b_errs got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic s;
    int nbad = 0;
    clear_obs();
    bus.tready = 1;
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, s);
      if (s) exp_q.push_back(d);
      else nbad++;
      send_bits(1'b1, s ? $urandom_range(0, cpb) : $urandom_range(2, cpb));
    end
    send_bits(1'b1, 2 * cpb);
    total++;
    if (got.size() != exp_q.size() || fe_cnt != nbad) begin
      bad++;
      $display("FAIL rand_count got n=%0d fe=%0d exp n=%0d fe=%0d", got.size(), fe_cnt, exp_q.size(), nbad);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_byte%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    bus.tready = 0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    send_bits(1'b1, cpb);
    total++;
    if (bus.tvalid !== 1'b1 || bus.tdata !== 8'h3C) begin
      bad++;
      $display("FAIL bp_hold got tvalid=%b tdata=%h exp 1 3c", bus.tvalid, bus.tdata);
    end
    total++;
    if (ov_cnt != 1 || got.size() != 0) begin
      bad++;
      $display("FAIL bp_overflow got ov=%0d n=%0d exp ov=1 n=0", ov_cnt, got.size());
    end
    bus.tready = 1;
    tick();
    bus.tready = 0;
    tick();
    total++;
    if (bus.tvalid !== 1'b0 || got.size() != 1 || got[0] !== 8'h3C) begin
      bad++;
      $display("FAIL bp_drain got tvalid=%b n=%0d exp tvalid=0 n=1 3c", bus.tvalid, got.size());
    end
  endtask

  task automatic test_same_cycle();
    clear_obs();
    bus.tready = 0;
    send_frame(8'h3C, 1'b1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (2 + half + 9 * cpb) @(posedge clk);
        #2 bus.tready = 1;
        @(posedge clk);
        #2 bus.tready = 0;
      end
    join
    send_bits(1'b1, cpb);
    total++;
    if (ov_cnt != 0) begin
      bad++;
      $display("FAIL same_ov got %0d exp 0", ov_cnt);
    end
    total++;
    if (bus.tvalid !== 1'b1 || bus.tdata !== 8'hC3) begin
      bad++;
      $display("FAIL same_data got tvalid=%b tdata=%h exp 1 c3", bus.tvalid, bus.tdata);
    end
    bus.tready = 1;
    tick();
    bus.tready = 0;
    tick();
    total++;
    if (got.size() != 2 || got[0] !== 8'h3C || got[1] !== 8'hC3 || bus.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL same_order got n=%0d tvalid=%b exp n=2 3c,c3 tvalid=0", got.size(), bus.tvalid);
    end
  endtask

  task automatic test_framing();
    clear_obs();
    bus.tready = 1;
    send_frame(8'hFF, 1'b0);
    total++;
    if (fe_cnt != 1 || got.size() != 0) begin
      bad++;
      $display("FAIL frame_err got fe=%0d n=%0d exp fe=1 n=0", fe_cnt, got.size());
    end
    send_bits(1'b0, 20 * cpb);
    send_bits(1'b1, cpb);
    send_frame(8'h55, 1'b1);
    send_bits(1'b1, cpb);
    total++;
    if (fe_cnt != 1 || got.size() != 1 || got[0] !== 8'h55) begin
      bad++;
      $display("FAIL break_recover got fe=%0d n=%0d exp fe=1 n=1 55", fe_cnt, got.size());
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    bus.tready = 1;
    send_bits(1'b0, half - 2);
    send_bits(1'b1, 2 * cpb);
    total++;
    if (got.size() != 0 || fe_cnt != 0 || bus.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_quiet got n=%0d fe=%0d tvalid=%b exp 0 0 0", got.size(), fe_cnt, bus.tvalid);
    end
    send_frame(8'h01, 1'b1);
    send_bits(1'b1, cpb);
    total++;
    if (got.size() != 1 || got[0] !== 8'h01) begin
      bad++;
      $display("FAIL glitch_next got n=%0d exp n=1 01", got.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    bus.tready = 0;
    send_frame(8'h5A, 1'b1);
    send_bits(1'b1, cpb);
    send_bits(1'b0, cpb);
    for (int i = 0; i < 4; i++) send_bits(1'b0, cpb);
    send_bits(1'b1, half);
    rst = 1;
    tick();
    tick();
    total++;
    if (bus.tvalid !== 1'b0 || bus.tdata !== 8'h00 || fe !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL midrst_out got tvalid=%b tdata=%h fe=%b ov=%b exp 0 00 0 0", bus.tvalid, bus.tdata, fe, ov);
    end
    rst = 0;
    send_bits(1'b1, 2 * cpb);
    bus.tready = 1;
    send_frame(8'h96, 1'b1);
    send_bits(1'b1, cpb);
    total++;
    if (got.size() != 1 || got[0] !== 8'h96 || fe_cnt != 0) begin
      bad++;
      $display("FAIL midrst_next got n=%0d fe=%0d exp n=1 96 fe=0", got.size(), fe_cnt);
    end
  endtask

  initial begin
    bus.tready = 0;
    test_reset();
    test_loopback();
    test_random();
    test_backpressure();
    test_same_cycle();
    test_framing();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
